axi_to_mem: RTL and testbench

//  AXI4 slave that converts single-ID AXI bursts into a simple one-beat-per-cycle memory/register

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 48 ++++
 rtl/axi_to_mem.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_to_mem.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI-to-memory bridge: burst type codes, response
// codes and the bridge FSM state encoding.
// ----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_READ   = 2'b01,
        ST_WRITE  = 2'b10,
        ST_SEND_B = 2'b11
    } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen
// Purely combinational AXI beat address generator: given the address of the
// current beat and the burst attributes, produces the address of the next beat.
//   addr      in   current beat address
//   len       in   AXI burst length (beats - 1)
//   size      in   log2 of bytes per beat
//   burst     in   burst type (FIXED / INCR / WRAP; reserved behaves as INCR)
//   next_addr out  address of the following beat
// ----------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] beat_bytes_s;
    logic [ADDR_WIDTH-1:0] incr_addr_s;
    logic [ADDR_WIDTH-1:0] wrap_mask_s;
    logic [ADDR_WIDTH-1:0] wrap_addr_s;

    // Linear successor: align down to the beat size, then step one beat.
    assign beat_bytes_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
    assign incr_addr_s  = (addr & ~(beat_bytes_s - {{(ADDR_WIDTH-1){1'b0}}, 1'b1})) + beat_bytes_s;

    // Wrap window is (len+1) beats; legal wrap lengths make it a power of two,
    // so the window base keeps the upper bits and the low bits roll over.
    assign wrap_mask_s  = ({{(ADDR_WIDTH-9){1'b0}}, {1'b0, len} + 9'd1} << size)
                          - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign wrap_addr_s  = (addr & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);

    // Select the successor by burst type.
    always_comb begin
        next_addr = incr_addr_s;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_addr_s;
            default:     next_addr = incr_addr_s;
        endcase
    end

endmodule

// File: rtl/axi_to_mem.sv
// ----------------------------------------------------------------------------
// axi_to_mem
// AXI4 slave that turns one burst at a time into a one-beat-per-cycle memory
// request port. Read data returns the cycle after a read request and is held
// in a register until the R handshake. Responses are always OKAY.
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   aw_* / ar_* / w_*              AXI request channels (lock/cache/prot/qos/
//                                  region/atop/user accepted but ignored)
//   b_* / r_*                      AXI response channels (user outputs are 0)
//   req_o, we_o, addr_o, be_o,     memory request port, one beat per cycle
//   data_o, data_i                 write data out, read data in (1-cycle)
// ----------------------------------------------------------------------------
module axi_to_mem
    import axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic                        aw_lock,
    input  logic [3:0]                  aw_cache,
    input  logic [2:0]                  aw_prot,
    input  logic [3:0]                  aw_qos,
    input  logic [3:0]                  aw_region,
    input  logic [5:0]                  aw_atop,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic                        ar_lock,
    input  logic [3:0]                  ar_cache,
    input  logic [2:0]                  ar_prot,
    input  logic [3:0]                  ar_qos,
    input  logic [3:0]                  ar_region,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    input  logic                        w_valid,
    output logic                        w_ready,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic                        req_o,
    output logic                        we_o,
    output logic [AXI_ADDR_WIDTH-1:0]   addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0] be_o,
    output logic [AXI_DATA_WIDTH-1:0]   data_o,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    state_e                      state_r;
    logic [AXI_ID_WIDTH-1:0]     id_r;
    logic [AXI_ADDR_WIDTH-1:0]   addr_r;     // address of the current beat
    logic [7:0]                  len_r;
    logic [7:0]                  beat_r;
    logic [2:0]                  size_r;
    logic [1:0]                  burst_r;
    logic                        rd_pend_r;  // read data arrives on data_i this cycle
    logic [AXI_DATA_WIDTH-1:0]   r_data_r;
    logic                        r_valid_r;
    logic                        r_last_r;
    logic                        b_valid_r;

    logic [AXI_ADDR_WIDTH-1:0]   next_addr_s;
    logic                        ar_hs_s;
    logic                        aw_hs_s;
    logic                        w_hs_s;
    logic                        r_next_s;
    logic                        unused_s;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_r),
        .len       (len_r),
        .size      (size_r),
        .burst     (burst_r),
        .next_addr (next_addr_s)
    );

    // Handshakes are refused while reset is held; AR wins over AW in IDLE.
    assign ar_ready = rst_ni & (state_r == ST_IDLE);
    assign aw_ready = ar_ready & ~ar_valid;
    assign w_ready  = (state_r == ST_WRITE);
    assign ar_hs_s  = ar_valid & ar_ready;
    assign aw_hs_s  = aw_valid & aw_ready;
    assign w_hs_s   = w_valid & w_ready;
    // Accepting a non-last R beat launches the next read in the same cycle.
    assign r_next_s = (state_r == ST_READ) & r_valid_r & r_ready & ~r_last_r;

    assign req_o    = ar_hs_s | w_hs_s | r_next_s;
    assign we_o     = w_hs_s;
    assign data_o   = w_data;
    assign be_o     = w_hs_s ? w_strb : {STRB_WIDTH{1'b1}};

    assign r_id     = id_r;
    assign r_data   = r_data_r;
    assign r_resp   = RESP_OKAY;
    assign r_last   = r_last_r;
    assign r_user   = {AXI_USER_WIDTH{1'b0}};
    assign r_valid  = r_valid_r;
    assign b_id     = id_r;
    assign b_resp   = RESP_OKAY;
    assign b_user   = {AXI_USER_WIDTH{1'b0}};
    assign b_valid  = b_valid_r;

    assign unused_s = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
                        ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user,
                        w_last, w_user};

    // Request address: fresh AR address, next read beat, or current write beat.
    always_comb begin
        addr_o = addr_r;
        if (ar_hs_s) begin
            addr_o = ar_addr;
        end else if (r_next_s) begin
            addr_o = next_addr_s;
        end else begin
            addr_o = addr_r;
        end
    end

    // Bridge FSM: latches the burst, counts beats and owns the response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            id_r      <= {AXI_ID_WIDTH{1'b0}};
            addr_r    <= {AXI_ADDR_WIDTH{1'b0}};
            len_r     <= 8'd0;
            beat_r    <= 8'd0;
            size_r    <= 3'd0;
            burst_r   <= 2'b00;
            rd_pend_r <= 1'b0;
            r_data_r  <= {AXI_DATA_WIDTH{1'b0}};
            r_valid_r <= 1'b0;
            r_last_r  <= 1'b0;
            b_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ar_hs_s) begin
                        state_r   <= ST_READ;
                        id_r      <= ar_id;
                        addr_r    <= ar_addr;
                        len_r     <= ar_len;
                        size_r    <= ar_size;
                        burst_r   <= ar_burst;
                        beat_r    <= 8'd0;
                        rd_pend_r <= 1'b1;
                    end else if (aw_hs_s) begin
                        state_r   <= ST_WRITE;
                        id_r      <= aw_id;
                        addr_r    <= aw_addr;
                        len_r     <= aw_len;
                        size_r    <= aw_size;
                        burst_r   <= aw_burst;
                        beat_r    <= 8'd0;
                    end
                end
                ST_READ: begin
                    if (rd_pend_r) begin
                        r_data_r  <= data_i;
                        r_valid_r <= 1'b1;
                        r_last_r  <= (beat_r == len_r);
                        rd_pend_r <= 1'b0;
                    end else if (r_valid_r && r_ready) begin
                        r_valid_r <= 1'b0;
                        if (r_last_r) begin
                            r_last_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            addr_r    <= next_addr_s;
                            beat_r    <= beat_r + 8'd1;
                            rd_pend_r <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // The beat count, not w_last, closes the burst.
                    if (w_hs_s) begin
                        addr_r <= next_addr_s;
                        beat_r <= beat_r + 8'd1;
                        if (beat_r == len_r) begin
                            state_r   <= ST_SEND_B;
                            b_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SEND_B: begin
                    if (b_ready) begin
                        b_valid_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_to_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_to_mem
// Directed plus randomized bench for axi_to_mem. A behavioural memory answers
// read requests one cycle later with an address-derived pattern; expected beat
// addresses come from closed-form burst arithmetic.
// ----------------------------------------------------------------------------
module tb_axi_to_mem;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr, addr_o;
    logic [7:0]  aw_len, ar_len, w_strb, be_o;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_lock, ar_lock;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [5:0]  aw_atop;
    logic [0:0]  aw_user, ar_user, w_user, b_user, r_user;
    logic        aw_valid, aw_ready, ar_valid, ar_ready;
    logic [63:0] w_data, r_data, data_o, data_i;
    logic        w_last, w_valid, w_ready;
    logic        b_valid, b_ready, r_last, r_valid, r_ready;
    logic        req_o, we_o;

    int checks = 0;
    int errors = 0;

    axi_to_mem dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
        .aw_qos(aw_qos), .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o),
        .data_i(data_i)
    );

    always #5 clk_i = ~clk_i;

    // Read data pattern returned by the memory for a given address.
    function automatic logic [63:0] rd_fn(input logic [31:0] a);
        return {a ^ 32'hA5A5_0F0F, ~a};
    endfunction

    // Behavioural memory: read data valid the cycle after a read request.
    always @(posedge clk_i) begin
        if (req_o && !we_o) data_i <= rd_fn(addr_o);
        else                data_i <= 64'hDEAD_BEEF_0BAD_F00D;
    end

    // Expected address of beat i of a burst, from AXI burst arithmetic.
    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i, input int len,
                                             input int size, input logic [1:0] burst);
        logic [31:0] sz, lin, win, base;
        sz   = 32'd1 << size;
        lin  = (a - (a % sz)) + 32'(i) * sz;
        win  = 32'(len + 1) * sz;
        base = a - (a % win);
        if (i == 0 || burst == 2'b00) return a;
        if (burst == 2'b10) return base + ((lin - base) % win);
        return lin;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full read burst; optionally stalls r_ready on one beat. Starts and ends at posedge+1.
    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n);
        logic [31:0] ea;
        bit got;
        ar_id = id; ar_addr = a; ar_len = 8'(len); ar_size = 3'(size); ar_burst = burst;
        ar_valid = 1'b1;
        @(negedge clk_i);
        check("ar_ready", ar_ready, 1);
        check("aw_ready_vs_ar", aw_ready, 0);
        check("rd_req0", req_o, 1);
        check("rd_we0", we_o, 0);
        check("rd_addr0", addr_o, a);
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                @(negedge clk_i);
                if (r_valid) got = 1'b1;
                else begin
                    check("rd_bubble_req", req_o, 0);
                    tick();
                end
            end
            check("r_valid_timeout", got, 1);
            ea = exp_addr(a, i, len, size, burst);
            check("r_data", r_data, rd_fn(ea));
            check("r_last", r_last, (i == len));
            check("r_id", r_id, id);
            check("r_resp", r_resp, 0);
            check("aw_ready_in_read", aw_ready, 0);
            if (i == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    @(negedge clk_i);
                    check("stall_r_valid", r_valid, 1);
                    check("stall_r_data", r_data, rd_fn(ea));
                    check("stall_req", req_o, 0);
                end
            end
            r_ready = 1'b1;
            #1;
            check("rd_next_req", req_o, (i != len));
            if (i != len) begin
                check("rd_next_we", we_o, 0);
                check("rd_next_addr", addr_o, exp_addr(a, i + 1, len, size, burst));
            end
            tick();
            r_ready = 1'b0;
        end
    endtask

    // Full write burst with optional idle gaps between beats.
    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input logic [1:0] burst,
                            input logic [63:0] d0, input logic [7:0] s0, input bit gaps);
        logic [63:0] d;
        logic [7:0]  s;
        bit got;
        aw_id = id; aw_addr = a; aw_len = 8'(len); aw_size = 3'(size); aw_burst = burst;
        aw_valid = 1'b1;
        @(negedge clk_i);
        check("aw_ready", aw_ready, 1);
        check("aw_cycle_req", req_o, 0);
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                w_valid = 1'b0;
                @(negedge clk_i);
                check("wr_gap_req", req_o, 0);
                check("wr_gap_w_ready", w_ready, 1);
                tick();
            end
            d = (i == 0) ? d0 : {$urandom, $urandom};
            s = (i == 0) ? s0 : 8'($urandom);
            w_data = d; w_strb = s; w_last = (i == len); w_valid = 1'b1;
            @(negedge clk_i);
            check("w_ready", w_ready, 1);
            check("wr_req", req_o, 1);
            check("wr_we", we_o, 1);
            check("wr_addr", addr_o, exp_addr(a, i, len, size, burst));
            check("wr_be", be_o, s);
            check("wr_data", data_o, d);
            check("wr_b_early", b_valid, 0);
            tick();
        end
        w_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk_i);
            if (b_valid) got = 1'b1;
            else tick();
        end
        check("b_valid_timeout", got, 1);
        check("b_id", b_id, id);
        check("b_resp", b_resp, 0);
        check("b_phase_req", req_o, 0);
        check("b_phase_w_ready", w_ready, 0);
        tick();
        @(negedge clk_i);
        check("b_hold", b_valid, 1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        @(negedge clk_i);
        check("b_clear", b_valid, 0);
        check("idle_ar_ready", ar_ready, 1);
        tick();
    endtask

    initial begin
        int sz, bt, ln, dir;
        logic [31:0] a;

        rst_ni = 1'b0;
        aw_id = 4'd0; aw_addr = 32'd0; aw_len = 8'd0; aw_size = 3'd0; aw_burst = 2'b00;
        aw_lock = 1'b0; aw_cache = 4'd0; aw_prot = 3'd0; aw_qos = 4'd0; aw_region = 4'd0;
        aw_atop = 6'd0; aw_user = 1'b0; aw_valid = 1'b0;
        ar_id = 4'd0; ar_addr = 32'd0; ar_len = 8'd0; ar_size = 3'd0; ar_burst = 2'b00;
        ar_lock = 1'b0; ar_cache = 4'd0; ar_prot = 3'd0; ar_qos = 4'd0; ar_region = 4'd0;
        ar_user = 1'b0; ar_valid = 1'b0;
        w_data = 64'd0; w_strb = 8'd0; w_last = 1'b0; w_user = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0; r_ready = 1'b0;

        // Reset state
        #3;
        check("rst_ar_ready", ar_ready, 0);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_req", req_o, 0);
        check("rst_we", we_o, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_id", r_id, 0);
        check("rst_b_id", b_id, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // 1. Single read
        do_read(4'd3, 32'h08, 0, 3, 2'b01, -1, 0);
        // 2. Single write
        do_write(4'd6, 32'h10, 0, 3, 2'b01, 64'h1122_3344_5566_7788, 8'h0F, 1'b0);
        // 3. INCR read, stalled on second beat
        do_read(4'd2, 32'h20, 3, 3, 2'b01, 1, 2);
        // 4. WRAP write and FIXED write
        do_write(4'd9, 32'h38, 3, 3, 2'b10, 64'hCAFE_F00D_0000_0001, 8'hFF, 1'b0);
        do_write(4'd1, 32'h44, 1, 2, 2'b00, 64'h0000_0000_ABCD_0123, 8'hF0, 1'b1);

        // 5. AR and AW together: read first, write after
        aw_id = 4'd5; aw_addr = 32'h80; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01;
        aw_valid = 1'b1;
        do_read(4'd4, 32'h200, 1, 3, 2'b01, -1, 0);
        do_write(4'd5, 32'h80, 0, 3, 2'b01, 64'h0123_4567_89AB_CDEF, 8'hA5, 1'b0);

        // 6a. Reset in the middle of a read burst
        ar_id = 4'd7; ar_addr = 32'h100; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'b01;
        ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        check("pre_rst_r_valid", r_valid, 1);
        r_ready = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_r_valid", r_valid, 0);
        check("mid_rst_req", req_o, 0);
        check("mid_rst_ar_ready", ar_ready, 0);
        check("mid_rst_r_data", r_data, 0);
        tick();
        r_ready = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        do_read(4'd8, 32'h300, 2, 2, 2'b01, -1, 0);

        // 6b. Reset in the middle of a write burst with w_valid still high
        aw_id = 4'd3; aw_addr = 32'h400; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'b01;
        aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        w_data = 64'h5555_AAAA_5555_AAAA; w_strb = 8'hFF; w_valid = 1'b1;
        tick();
        rst_ni = 1'b0;
        #1;
        check("wr_rst_req", req_o, 0);
        check("wr_rst_w_ready", w_ready, 0);
        check("wr_rst_b_valid", b_valid, 0);
        w_valid = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        @(negedge clk_i);
        check("post_rst_no_b", b_valid, 0);
        tick();

        // Randomized bursts
        for (int n = 0; n < 14; n++) begin
            sz  = $urandom_range(0, 3);
            bt  = $urandom_range(0, 3);
            dir = $urandom_range(0, 1);
            if (bt == 2) ln = (1 << $urandom_range(1, 3)) - 1;
            else         ln = $urandom_range(0, 7);
            a = $urandom & 32'h0000_FFFF;
            if (bt == 2) a = a & ~((32'd1 << sz) - 32'd1);
            if (dir == 1)
                do_read(4'($urandom), a, ln, sz, 2'(bt), $urandom_range(0, ln), $urandom_range(0, 2));
            else
                do_write(4'($urandom), a, ln, sz, 2'(bt), {$urandom, $urandom}, 8'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
